uart_rx: RTL and testbench

//   Serial UART receiver: 8 data bits, LSB first, no parity, 1 stop bit (8N1), idle-high line.

---
 rtl/uart_rx.sv | 138 +++++++++++++
 tb/tb_uart_rx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronised input, falling-edge start detect, mid-bit sampling,
// valid/ack byte handshake with sticky overrun and one-cycle framing-error pulse.
module uart_rx #(
    parameter int CLK_MHZ = 12,
    parameter int BAUD    = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] recvData,
    output logic       recvValid,
    input  logic       recvAck,
    output logic       overrun,
    output logic       frameErr,
    output logic       busy
);
    localparam int BIT  = (1000000 * CLK_MHZ) / BAUD;
    localparam int HALF = BIT / 2;
    localparam logic [15:0] BIT_M1  = 16'(BIT - 1);
    localparam logic [15:0] HALF_M1 = 16'(HALF - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_IDLE
    } state_t;

    state_t      r_state;
    logic        r_rx_meta;
    logic        r_rx_s;
    logic        r_rx_p;
    logic [15:0] r_cnt;
    logic [2:0]  r_bitcnt;
    logic [7:0]  r_shift;
    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_overrun;
    logic        r_frame_err;
    logic        w_start_edge;

    // Regs reset low so a line held low through reset cannot fake a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b0;
            r_rx_s    <= 1'b0;
            r_rx_p    <= 1'b0;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_rx_p    <= r_rx_s;
        end
    end

    assign w_start_edge = r_rx_p && !r_rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 16'd0;
            r_bitcnt    <= 3'd0;
            r_shift     <= 8'd0;
            r_data      <= 8'd0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            if (recvAck && r_valid) begin
                r_valid   <= 1'b0;
                r_overrun <= 1'b0;
            end
            if (r_cnt != 16'd0) begin
                r_cnt <= r_cnt - 16'd1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_start_edge) begin
                        r_cnt   <= HALF_M1;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (r_cnt == 16'd0) begin
                        if (!r_rx_s) begin
                            r_cnt    <= BIT_M1;
                            r_bitcnt <= 3'd0;
                            r_state  <= ST_DATA;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    if (r_cnt == 16'd0) begin
                        r_shift  <= {r_rx_s, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                        r_cnt    <= BIT_M1;
                        if (r_bitcnt == 3'd7) begin
                            r_state <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (r_cnt == 16'd0) begin
                        if (r_rx_s) begin
                            // A coincident ack consumes the old byte, so overrun is only set without one.
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                            if (r_valid && !recvAck) begin
                                r_overrun <= 1'b1;
                            end
                            r_state <= ST_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= ST_WAIT_IDLE;
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    if (r_rx_s) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign recvData  = r_data;
    assign recvValid = r_valid;
    assign overrun   = r_overrun;
    assign frameErr  = r_frame_err;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with CLK_MHZ=1, BAUD=10000 (BIT=100, HALF=50 cycles).
module tb_uart_rx;
    localparam int BITP = 100;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] recvData;
    logic       recvValid;
    logic       recvAck;
    logic       overrun;
    logic       frameErr;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rise_cyc = 0;
    int t_fall   = 0;
    int fe_count = 0;
    int fe_base  = 0;
    logic busy_seen  = 1'b0;
    logic valid_prev = 1'b0;
    logic [7:0] exp_q [16];

    uart_rx #(.CLK_MHZ(1), .BAUD(10000)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .recvData  (recvData),
        .recvValid (recvValid),
        .recvAck   (recvAck),
        .overrun   (overrun),
        .frameErr  (frameErr),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (recvValid && !valid_prev) rise_cyc = cyc;
        valid_prev = recvValid;
        if (frameErr) fe_count = fe_count + 1;
        if (busy) busy_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Drives one 8N1 frame starting at a negedge; optional one-cycle ack/reset at frame offset k.
    task automatic send_frame(input logic [7:0] b, input int p, input int ack_at, input int rst_at);
        logic [9:0] bits;
        bits   = {1'b1, b, 1'b0};
        t_fall = cyc;
        for (int k = 0; k < 10 * p; k++) begin
            rx = bits[k / p];
            if (ack_at >= 0) recvAck = (k == ack_at);
            if (rst_at >= 0) rst = (k == rst_at);
            @(negedge clk);
        end
        if (ack_at >= 0) recvAck = 1'b0;
        if (rst_at >= 0) rst = 1'b0;
        rx = 1'b1;
    endtask

    task automatic ack_pulse();
        recvAck = 1'b1;
        @(negedge clk);
        recvAck = 1'b0;
    endtask

    task automatic send_bytes(input int p);
        for (int i = 0; i < 16; i++) send_frame(exp_q[i], p, -1, -1);
    endtask

    task automatic collect();
        for (int i = 0; i < 16; i++) begin
            int w;
            w = 0;
            while (!recvValid && w < 3000) begin
                @(negedge clk);
                w++;
            end
            chk("b2b_wait_expired", (w < 3000), 1'b1);
            chk("b2b_valid", recvValid, 1'b1);
            chk("b2b_byte", recvData, exp_q[i]);
            $display("b2b byte %0d: got %02h want %02h", i, recvData, exp_q[i]);
            ack_pulse();
        end
    endtask

    initial begin
        rst = 1'b1;
        rx = 1'b0;
        recvAck = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        chk("reset_low_busy", busy, 1'b0);
        chk("reset_valid", recvValid, 1'b0);
        chk("reset_data", recvData, 8'h00);
        chk("reset_overrun", overrun, 1'b0);
        chk("reset_frameerr", frameErr, 1'b0);
        rx = 1'b1;
        repeat (20) @(negedge clk);

        // Single frame, latency from rx fall to recvValid
        fe_base = fe_count;
        send_frame(8'hA5, BITP, -1, -1);
        $display("frame A5: latency %0d data %02h", rise_cyc - t_fall, recvData);
        chk("t1_latency", rise_cyc - t_fall, 953);
        chk("t1_data", recvData, 8'hA5);
        chk("t1_valid", recvValid, 1'b1);
        chk("t1_frameerr", fe_count - fe_base, 0);
        ack_pulse();
        chk("t1_ack_clears", recvValid, 1'b0);
        ack_pulse();
        chk("t1_idle_ack_valid", recvValid, 1'b0);
        repeat (20) @(negedge clk);

        // Short low glitch
        busy_seen = 1'b0;
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (100) @(negedge clk);
        $display("glitch: busy_seen %0b busy %0b", busy_seen, busy);
        chk("t2_busy_pulsed", busy_seen, 1'b1);
        chk("t2_busy_idle", busy, 1'b0);
        chk("t2_valid", recvValid, 1'b0);
        chk("t2_frameerr", fe_count - fe_base, 0);

        // Break: line low 20 bit times
        t_fall = cyc;
        rx = 1'b0;
        repeat (20 * BITP - 1) @(negedge clk);
        chk("t3_busy_in_break", busy, 1'b1);
        @(negedge clk);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        $display("break: frameErr cycles %0d busy %0b", fe_count - fe_base, busy);
        chk("t3_frameerr_pulse", fe_count - fe_base, 1);
        chk("t3_valid", recvValid, 1'b0);
        chk("t3_busy_after", busy, 1'b0);
        send_frame(8'h5A, BITP, -1, -1);
        chk("t3_next_data", recvData, 8'h5A);
        chk("t3_next_valid", recvValid, 1'b1);
        ack_pulse();

        // Overrun
        send_frame(8'h11, BITP, -1, -1);
        send_frame(8'h22, BITP, -1, -1);
        $display("overrun: data %02h valid %0b overrun %0b", recvData, recvValid, overrun);
        chk("t4_data", recvData, 8'h22);
        chk("t4_overrun", overrun, 1'b1);
        chk("t4_valid", recvValid, 1'b1);
        ack_pulse();
        chk("t4_ack_valid", recvValid, 1'b0);
        chk("t4_ack_overrun", overrun, 1'b0);
        send_frame(8'h11, BITP, -1, -1);
        send_frame(8'h33, BITP, -1, -1);
        chk("t4b_overrun_set", overrun, 1'b1);
        send_frame(8'h22, BITP, 952, -1);
        $display("coincident ack: data %02h valid %0b overrun %0b", recvData, recvValid, overrun);
        chk("t4b_data", recvData, 8'h22);
        chk("t4b_valid", recvValid, 1'b1);
        chk("t4b_overrun", overrun, 1'b0);

        // Reset mid-frame (data bit 4, rx low)
        send_frame(8'h0F, BITP, -1, 550);
        repeat (20) @(negedge clk);
        $display("mid-frame reset: data %02h valid %0b busy %0b", recvData, recvValid, busy);
        chk("t5_valid", recvValid, 1'b0);
        chk("t5_data", recvData, 8'h00);
        chk("t5_overrun", overrun, 1'b0);
        chk("t5_busy", busy, 1'b0);
        send_frame(8'h3C, BITP, -1, -1);
        chk("t5_next_data", recvData, 8'h3C);
        ack_pulse();
        repeat (20) @(negedge clk);

        // Back-to-back at slow and fast sender clocks
        for (int i = 0; i < 16; i++) exp_q[i] = 8'($urandom_range(0, 255));
        fe_base = fe_count;
        fork
            send_bytes(101);
            collect();
        join
        chk("t6_slow_overrun", overrun, 1'b0);
        chk("t6_slow_frameerr", fe_count - fe_base, 0);
        repeat (20) @(negedge clk);
        for (int i = 0; i < 16; i++) exp_q[i] = 8'($urandom_range(0, 255));
        fork
            send_bytes(98);
            collect();
        join
        chk("t6_fast_overrun", overrun, 1'b0);
        chk("t6_fast_frameerr", fe_count - fe_base, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
